// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_1 = 2'd1,
        GNT_2 = 2'd2
    } state_e;

    // Select encodings for the datapath mux.
    localparam logic SEL_1 = 1'b0;
    localparam logic SEL_2 = 1'b1;

    // Width of the per-grant burst counter.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mux_arbiter_if.sv
// Handshake and data bundle between two producers, the arbiter and the consumer.
interface mux_arbiter_if;

    logic       req_1;
    logic [3:0] data_1;
    logic       ack_1;
    logic       req_2;
    logic [3:0] data_2;
    logic       ack_2;
    logic       sel;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Arbiter side.
    modport slave (
        input  req_1, data_1, req_2, data_2, out_ready,
        output ack_1, ack_2, sel, out_data, out_valid
    );

    // Producer/consumer side.
    modport master (
        output req_1, data_1, req_2, data_2, out_ready,
        input  ack_1, ack_2, sel, out_data, out_valid
    );

endinterface

// File: rtl/standard_mux.sv
// Team 4-bit 2:1 datapath mux: in_3 = 0 selects in_1, in_3 = 1 selects in_2.
module standard_mux (
    input  logic [3:0] in_1,
    input  logic [3:0] in_2,
    input  logic       in_3,
    output logic [3:0] out_1
);

    // Plain combinational select.
    always_comb begin
        out_1 = in_3 ? in_2 : in_1;
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing the 4-bit datapath mux between two requesters,
// granting bursts of up to MAX_BURST words before rotating priority.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_arbiter_if.slave  arb
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;   // 0: requester 1 served last
    logic             r_sel;

    logic             w_out_valid;
    logic             w_xfer;
    logic             w_burst_end;
    logic [3:0]       w_out_data;

    // Offer and acknowledge depend only on state and requests, never on out_ready for valid.
    always_comb begin
        w_out_valid = ((r_state == GNT_1) && arb.req_1) || ((r_state == GNT_2) && arb.req_2);
        w_xfer      = w_out_valid && arb.out_ready;
        w_burst_end = w_xfer && (r_cnt == CNT_LAST);
    end

    assign arb.out_valid = w_out_valid;
    assign arb.ack_1     = w_xfer && (r_state == GNT_1);
    assign arb.ack_2     = w_xfer && (r_state == GNT_2);
    assign arb.sel       = r_sel;
    assign arb.out_data  = w_out_data;

    standard_mux u_mux (
        .in_1  (arb.data_1),
        .in_2  (arb.data_2),
        .in_3  (r_sel),
        .out_1 (w_out_data)
    );

    // Arbitration FSM with burst counter, round-robin pointer and registered select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_sel   <= SEL_1;
        end else begin
            case (r_state)
                IDLE: begin
                    // On a tie, grant the requester that was not served last.
                    if (arb.req_1 && (!arb.req_2 || r_last)) begin
                        r_state <= GNT_1;
                        r_sel   <= SEL_1;
                    end else if (arb.req_2) begin
                        r_state <= GNT_2;
                        r_sel   <= SEL_2;
                    end
                end
                GNT_1: begin
                    if (!arb.req_1 || w_burst_end) begin
                        r_last <= 1'b0;
                        r_cnt  <= '0;
                        if (arb.req_2) begin
                            r_state <= GNT_2;
                            r_sel   <= SEL_2;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                GNT_2: begin
                    if (!arb.req_2 || w_burst_end) begin
                        r_last <= 1'b1;
                        r_cnt  <= '0;
                        if (arb.req_1) begin
                            r_state <= GNT_1;
                            r_sel   <= SEL_1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
